// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: shared constants and types for the data-memory responder.
//   - MMIO register addresses (CONSOLE / STATUS / CYCLE)
//   - STATUS bit positions
//   - access request struct and address-region decode helper
package dmem_resp_pkg;

  localparam logic [11:0] CONSOLE_ADDR = 12'hFF0;
  localparam logic [11:0] STATUS_ADDR  = 12'hFF1;
  localparam logic [11:0] CYCLE_ADDR   = 12'hFF2;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        we;
  } dmem_req_t;

  typedef enum logic [2:0] {
    RG_RAM,
    RG_CONSOLE,
    RG_STATUS,
    RG_CYCLE,
    RG_NONE
  } region_e;

  // Anything at or above mmio_base that is not a named register is a hole
  // (reads 0, writes ignored).
  function automatic region_e decode_addr(input logic [11:0] addr,
                                          input logic [11:0] mmio_base);
    if (addr < mmio_base)          return RG_RAM;
    else if (addr == CONSOLE_ADDR) return RG_CONSOLE;
    else if (addr == STATUS_ADDR)  return RG_STATUS;
    else if (addr == CYCLE_ADDR)   return RG_CYCLE;
    else                           return RG_NONE;
  endfunction

endpackage

// File: rtl/dmem_resp_fifo.sv
// dmem_resp_fifo: synchronous FIFO, power-of-two DEPTH, same-cycle push+pop.
//   clock, reset (async, active low)
//   push/din  : enqueue request; accepted when not full, or when full and a
//               pop happens in the same cycle
//   pop       : dequeue request; ignored when empty
//   dout      : head entry, forced to 0 while empty
//   full/empty: occupancy flags
module dmem_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot this push needs, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage is not reset; pointers and count define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dmem_bus_responder.sv
// dmem_bus_responder: responder for the processor data-memory port.
//   Words 0..MMIO_BASE-1 hit a word RAM; the top of the 12-bit space is MMIO:
//     0xFF0 CONSOLE  write pushes data[7:0] into the console FIFO, reads 0
//     0xFF1 STATUS   read {29'b0, overflow, full, empty}; write data[2]=1
//                    clears overflow
//     0xFF2 CYCLE    free-running counter, writable (only when the macro
//                    DMEM_RESP_CYCLE_CNT_EN is defined; otherwise reads 0)
//   Ports:
//     clock, reset (async, active low)
//     address_dmem/data/wren : one access per cycle
//     q_dmem                 : registered read data, 1-cycle latency
//     tx_data/tx_valid/tx_ready : console byte stream out
module dmem_bus_responder
  import dmem_resp_pkg::*;
#(
  parameter logic [11:0] MMIO_BASE  = 12'hFF0,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  dmem_req_t   req;
  region_e     region;
  logic [31:0] ram [0:MMIO_BASE-1];
  logic        fifo_push, fifo_full, fifo_empty;
  logic        overflow;
  logic [31:0] status_word, cyc_rd, rd_data;

  assign req    = '{addr: address_dmem, wdata: data, we: wren};
  assign region = decode_addr(req.addr, MMIO_BASE);

  // RAM: write lands on the edge; the same edge samples the old word into
  // q_dmem, giving read-old-data on a same-address read/write.
  always_ff @(posedge clock) begin
    if (req.we && region == RG_RAM) ram[req.addr] <= req.wdata;
  end

  // Console FIFO
  assign fifo_push = req.we && region == RG_CONSOLE;
  assign tx_valid  = !fifo_empty;

  dmem_resp_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .din   (req.wdata[7:0]),
    .pop   (tx_ready),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A push into a full FIFO is only lost when nothing drains that cycle
  // (full implies tx_valid, so tx_ready alone means a pop happens).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      overflow <= 1'b0;
    else if (fifo_push && fifo_full && !tx_ready)
      overflow <= 1'b1;
    else if (req.we && region == RG_STATUS && req.wdata[ST_OVF])
      overflow <= 1'b0;
  end

  always_comb begin
    status_word           = '0;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_OVF]   = overflow;
  end

`ifdef DMEM_RESP_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cycle_cnt <= '0;
    else if (req.we && region == RG_CYCLE)
      cycle_cnt <= req.wdata;
    else
      cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign cyc_rd = cycle_cnt;
`else
  assign cyc_rd = '0;
`endif

  // Register reads see pre-edge state because q_dmem samples the current
  // flops on the same edge that updates them.
  always_comb begin
    rd_data = '0;
    case (region)
      RG_RAM:    rd_data = ram[req.addr];
      RG_STATUS: rd_data = status_word;
      RG_CYCLE:  rd_data = cyc_rd;
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q_dmem <= '0;
    else        q_dmem <= rd_data;
  end

endmodule

// File: tb/tb_dmem_bus_responder.sv
module tb_dmem_bus_responder;

  localparam logic [11:0] A_CON  = 12'hFF0;
  localparam logic [11:0] A_ST   = 12'hFF1;
  localparam logic [11:0] A_CYC  = 12'hFF2;
  localparam logic [11:0] A_IDLE = 12'hFF3;
  localparam int          DEPTH  = 8;

  logic        clock, reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  dmem_bus_responder #(.MMIO_BASE(12'hFF0), .FIFO_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: behaviour of the memory map, not of the RTL structure.
  logic [31:0] ram_m [logic [11:0]];
  logic [7:0]  fifo_m [$];
  bit          ovf_m;
  logic [31:0] cnt_m;
  logic [31:0] exp_q;
  bit          exp_known;
  logic [7:0]  pushed [9];

  function automatic void model_reset();
    fifo_m.delete();
    ovf_m = 0;
    cnt_m = 0;
  endfunction

  // One bus cycle: drive at negedge, predict, clock, return at next negedge.
  task automatic access(input logic [11:0] a, input logic [31:0] d,
                        input logic we, input logic rdy);
    bit pop, was_full;
    address_dmem = a; data = d; wren = we; tx_ready = rdy;
    exp_known = 1; exp_q = 0;
    if (a < 12'hFF0) begin
      if (ram_m.exists(a)) exp_q = ram_m[a];
      else exp_known = 0;
    end else if (a == A_ST) begin
      exp_q = {29'b0, ovf_m, fifo_m.size() == DEPTH, fifo_m.size() == 0};
    end else if (a == A_CYC) begin
`ifdef DMEM_RESP_CYCLE_CNT_EN
      exp_q = cnt_m;
`else
      exp_q = 0;
`endif
    end
    pop      = rdy && fifo_m.size() != 0;
    was_full = fifo_m.size() == DEPTH;
    if (we && a < 12'hFF0) ram_m[a] = d;
    if (pop) void'(fifo_m.pop_front());
    if (we && a == A_CON) begin
      if (!was_full || pop) fifo_m.push_back(d[7:0]);
      else ovf_m = 1;
    end
    if (we && a == A_ST && d[2]) ovf_m = 0;
    if (we && a == A_CYC) cnt_m = d;
    else cnt_m = cnt_m + 1;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input logic rdy);
    access(A_IDLE, 32'h0, 1'b0, rdy);
  endtask

  task automatic test_reset();
    reset = 0; address_dmem = A_IDLE; data = 0; wren = 0; tx_ready = 0;
    #1;
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL reset_q got=%h exp=0", q_dmem); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h0) begin errors++; $display("FAIL reset_tx_data got=%h exp=0", tx_data); end
    @(negedge clock);
    reset = 1;
    model_reset();
    access(A_ST, 0, 0, 0);
    checks++; if (q_dmem !== 32'h1) begin errors++; $display("FAIL reset_status got=%h exp=1", q_dmem); end
    access(A_CYC, 0, 0, 0);
    checks++; if (q_dmem !== exp_q) begin errors++; $display("FAIL reset_cycle got=%h exp=%h", q_dmem, exp_q); end
  endtask

  task automatic test_ram();
    access(12'h010, 32'hDEADBEEF, 1, 0);
    access(12'h010, 0, 0, 0);
    checks++; if (q_dmem !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_read got=%h exp=deadbeef", q_dmem); end
    access(12'h010, 32'h1, 1, 0);
    checks++; if (q_dmem !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rdw_old got=%h exp=deadbeef", q_dmem); end
    access(12'hFEF, 32'h12345678, 1, 0);
    access(12'h010, 0, 0, 0);
    checks++; if (q_dmem !== 32'h1) begin errors++; $display("FAIL ram_after_write got=%h exp=1", q_dmem); end
    access(12'hFEF, 0, 0, 0);
    checks++; if (q_dmem !== 32'h12345678) begin errors++; $display("FAIL ram_top_word got=%h exp=12345678", q_dmem); end
  endtask

  task automatic test_console();
    logic [7:0] b [3];
    b[0] = 8'h41; b[1] = 8'h42; b[2] = 8'h43;
    access(A_CON, 32'hFFFF_FF41, 1, 0);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL console_push_latency valid=%b data=%h exp 1/41", tx_valid, tx_data); end
    access(A_CON, 32'h42, 1, 0);
    access(A_CON, 32'h43, 1, 0);
    access(A_CON, 0, 0, 0);
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL console_read got=%h exp=0", q_dmem); end
    access(A_ST, 0, 0, 0);
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL console_status got=%h exp=0", q_dmem); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== b[i]) begin errors++; $display("FAIL console_stream[%0d] valid=%b data=%h exp 1/%h", i, tx_valid, tx_data, b[i]); end
      idle(1);
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL console_drained valid=%b exp=0", tx_valid); end
    access(A_ST, 0, 0, 0);
    checks++; if (q_dmem !== 32'h1) begin errors++; $display("FAIL console_status_empty got=%h exp=1", q_dmem); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      pushed[i] = 8'($urandom);
      access(A_CON, {24'h0, pushed[i]}, 1, 0);
    end
    access(A_ST, 0, 0, 0);
    checks++; if (q_dmem !== 32'h6) begin errors++; $display("FAIL ovf_status got=%h exp=6", q_dmem); end
    access(A_ST, 32'h4, 1, 0);
    access(A_ST, 0, 0, 0);
    checks++; if (q_dmem !== 32'h2) begin errors++; $display("FAIL ovf_clear got=%h exp=2", q_dmem); end
  endtask

  // Runs after test_overflow: FIFO holds pushed[0..7], pushed[8] was dropped.
  task automatic test_full_push_pop();
    logic [7:0] got [$];
    checks++; if (tx_data !== pushed[0]) begin errors++; $display("FAIL fpp_head got=%h exp=%h", tx_data, pushed[0]); end
    access(A_CON, 32'h55, 1, 1);
    access(A_ST, 0, 0, 0);
    checks++; if (q_dmem !== 32'h2) begin errors++; $display("FAIL fpp_status got=%h exp=2", q_dmem); end
    for (int n = 0; n < 20 && tx_valid === 1'b1; n++) begin
      got.push_back(tx_data);
      idle(1);
    end
    checks++; if (got.size() != 8) begin errors++; $display("FAIL fpp_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 7 && i < got.size(); i++) begin
      checks++; if (got[i] !== pushed[i+1]) begin errors++; $display("FAIL fpp_byte[%0d] got=%h exp=%h", i, got[i], pushed[i+1]); end
    end
    if (got.size() >= 8) begin
      checks++; if (got[7] !== 8'h55) begin errors++; $display("FAIL fpp_eighth got=%h exp=55", got[7]); end
    end
  endtask

  task automatic test_counter();
    access(A_CYC, 32'hFFFF_FFFE, 1, 0);
    idle(0);
    access(A_CYC, 0, 0, 0);
`ifdef DMEM_RESP_CYCLE_CNT_EN
    checks++; if (q_dmem !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cyc_max got=%h exp=ffffffff", q_dmem); end
`else
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL cyc_absent got=%h exp=0", q_dmem); end
`endif
    access(A_CYC, 0, 0, 0);
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL cyc_wrap got=%h exp=0", q_dmem); end
    access(A_CYC, 0, 0, 0);
    checks++; if (q_dmem !== exp_q) begin errors++; $display("FAIL cyc_post_wrap got=%h exp=%h", q_dmem, exp_q); end
    access(12'hFF7, 32'hFFFF_FFFF, 1, 0);
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL hole_read got=%h exp=0", q_dmem); end
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic        rdy;
    int          r;
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: a = 12'($urandom_range(0, 15));
        4, 5:       a = A_CON;
        6:          a = A_ST;
        7:          a = A_CYC;
        8:          a = 12'($urandom_range(12'hFF3, 12'hFFF));
        default:    a = 12'hFEF;
      endcase
      // Alternate long fill and drain phases so full/overflow get exercised.
      rdy = ((n / 64) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      access(a, $urandom, 1'($urandom_range(0, 1)), rdy);
      if (exp_known) begin
        checks++; if (q_dmem !== exp_q) begin errors++; $display("FAIL rnd_q cyc=%0d addr=%h got=%h exp=%h", n, a, q_dmem, exp_q); end
      end
      checks++; if (tx_valid !== (fifo_m.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, tx_valid, fifo_m.size() != 0); end
      if (fifo_m.size() != 0) begin
        checks++; if (tx_data !== fifo_m[0]) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", n, tx_data, fifo_m[0]); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int n = 0; n < 20 && fifo_m.size() != 0; n++) idle(1);
    access(A_CON, 32'hA1, 1, 0);
    access(A_CON, 32'hA2, 1, 0);
    access(A_CON, 32'hA3, 1, 0);
    access(12'h010, 0, 0, 0);
    checks++; if (tx_valid !== 1'b1 || q_dmem === 32'h0) begin errors++; $display("FAIL mid_pre valid=%b q=%h exp 1/nonzero", tx_valid, q_dmem); end
    address_dmem = A_CON; data = 32'hB0; wren = 1; tx_ready = 1;
    #2 reset = 0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h0) begin errors++; $display("FAIL mid_data got=%h exp=0", tx_data); end
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL mid_q got=%h exp=0", q_dmem); end
    @(negedge clock);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_hold_valid got=%b exp=0", tx_valid); end
    reset = 1;
    model_reset();
    access(A_ST, 0, 0, 0);
    checks++; if (q_dmem !== 32'h1) begin errors++; $display("FAIL mid_status got=%h exp=1", q_dmem); end
    access(A_CYC, 0, 0, 0);
    checks++; if (q_dmem !== exp_q) begin errors++; $display("FAIL mid_cycle got=%h exp=%h", q_dmem, exp_q); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_console();
    test_overflow();
    test_full_push_pop();
    test_counter();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
